imem_pipelined: RTL and testbench
=================================

# imem_pipelined

Parametrised synchronous instruction memory for the fetch stage of the RISC-V pipeline. Accepts fetch requests on a valid/ready handshake, returns FETCH_WORDS consecutive instruction words after a configurable read latency, and absorbs fetch-stage back-pressure in an internal response buffer. Supports a flush for branch/jump redirects and reports misaligned and out-of-range fetches instead of silently aliasing.

## Interface
- ADDR_WIDTH, XLEN: byte-address width.
- MEM_DEPTH, 1024: number of XLEN-bit words; power of two.
- FETCH_WORDS, 1: words returned per request; 1, 2 or 4.
- LATENCY, 1: cycles from request acceptance to earliest response; 1..4.
- INIT_FILE, "": hex image loaded at elaboration; empty means no preload.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_WIDTH  byte address of first word.
- flush  in  1  discard all outstanding responses.
- rsp_valid  out  1  response at buffer head.
- rsp_ready  in  1  consumer takes response.
- rsp_addr  out  ADDR_WIDTH  request address echoed.
- rsp_instr  out  FETCH_WORDS*XLEN  word i in bits [i*XLEN +: XLEN].
- rsp_fault  out  2  bit0 misaligned, bit1 out_of_range.

## Operation
- Accept on req_valid && req_ready at a rising edge; read memory in stage 1, carry data/addr/fault through LATENCY-1 further register stages, then write into response buffer.
- Word index = req_addr[INDEX_WIDTH+1:2], INDEX_WIDTH = $clog2(MEM_DEPTH); word i reads index+i.
- Misaligned: req_addr[1:0] != 0. Response carries all-NOP words (32'h0000_0013), bit0 set.
- Out of range: any req_addr bit above INDEX_WIDTH+1 set → all words NOP, bit1 set. Base in range but index+i >= MEM_DEPTH → only those words NOP, bit1 set. No wrap-around.
- Both fault bits may be set together.
- Credit counter `outstanding` = in pipeline + in buffer; +1 on accept, −1 on pop (rsp_valid && rsp_ready), both → unchanged. CREDITS = LATENCY+2; req_ready = rst_n && outstanding < CREDITS. req_ready never depends combinationally on rsp_ready, req_valid or flush.
- Buffer depth CREDITS, FIFO order; never overflows by construction.
- Flush at an edge: invalidate all pipeline stages and empty buffer, outstanding := 0. A request accepted at the same edge (redirect target) survives and counts 1. Pop in the same cycle as flush is ignored.
- Memory contents are never reset; writes are not supported.

## Timing
- Reset values: rsp_valid 0, req_ready 0 while rst_n low, 1 first cycle after release; rsp_addr/rsp_instr/rsp_fault 0; outstanding 0; pipeline valid bits 0.
- Reset mid-operation: all in-flight requests lost, no response emitted.
- Latency: request accepted at edge k, buffer empty → rsp_valid high after edge k+LATENCY.
- rsp_* held stable while rsp_valid && !rsp_ready.
- Throughput: one request per cycle sustained with rsp_ready held high.
- rsp_ready low: at most CREDITS requests accepted, then req_ready low until a pop.

## Structure
- Shared package: XLEN, NOP_INSTR constant, fault bit positions (FAULT_MISALIGNED=0, FAULT_OOR=1) as a packed struct imem_fault_t.
- Sub-module imem_rsp_fifo: synchronous FIFO, parametrised width/depth, push/pop/clear, head always visible; used for the response buffer.
- Memory array, fault decode and pipeline registers live in imem_pipelined.

## Test plan
- LATENCY=1, FETCH_WORDS=1, image 0x00500093, 0x00100113: request 0x0 then 0x4 back-to-back, rsp_ready=1 → responses 0x00500093, 0x00100113 after edges k+1, k+2, fault 0.
- LATENCY=3: 20 consecutive requests with rsp_ready=1 → req_ready never drops, 20 responses in order, one per cycle.
- LATENCY=2, rsp_ready=0: req_valid held → exactly 4 accepted, req_ready low; raise rsp_ready → 4 responses in order, req_ready returns high.
- FETCH_WORDS=2, MEM_DEPTH=1024: addr 0xFFC → word0 = mem[1023], word1 = 0x00000013, fault=2'b10; addr 0x6 → both NOP, fault=2'b01; addr 0x1000 → fault=2'b10.
- Three requests outstanding, flush with new request 0x40 same edge → only response for 0x40 appears, after LATENCY cycles.
- Reset asserted with responses buffered → rsp_valid 0 immediately, no stale response after release.

Source files
------------

// File: rtl/imem_pipelined_pkg.sv
// Shared definitions for the pipelined instruction memory.
//   XLEN             - instruction word width in bits
//   NOP_INSTR        - filler word returned in place of faulting fetch words (addi x0, x0, 0)
//   FAULT_MISALIGNED - bit position of the misaligned flag in a fault vector
//   FAULT_OOR        - bit position of the out-of-range flag in a fault vector
//   imem_fault_t     - packed fault vector {oor, misaligned}
package imem_pipelined_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned FAULT_MISALIGNED = 0;
  localparam int unsigned FAULT_OOR        = 1;

  // Field order places misaligned at bit 0 and oor at bit 1.
  typedef struct packed {
    logic oor;
    logic misaligned;
  } imem_fault_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous FIFO used as the fetch response buffer.
//   clk_i       - clock, rising edge
//   rst_ni      - asynchronous active-low reset (storage and pointers to zero)
//   clear_i     - empty the FIFO at the next edge; overrides push and pop
//   push_i      - write push_data_i at the tail (ignored when full and not popping)
//   push_data_i - entry to write
//   pop_i       - drop the head entry (ignored when empty)
//   head_o      - head entry, always visible
//   empty_o     - no entries stored
module imem_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] storage_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = storage_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push && !clear_i) begin
        storage_q[wptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/imem_pipelined.sv
// Pipelined instruction memory for the fetch stage.
// A request accepted on req_valid && req_ready reads FETCH_WORDS consecutive words, travels
// through LATENCY register stages and lands in a response buffer of LATENCY+2 entries.
// A credit counter covering pipeline plus buffer guarantees the buffer never overflows.
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req_valid - fetch request present
//   req_ready - a request can be accepted
//   req_addr  - byte address of the first word
//   flush     - discard everything outstanding; a request accepted at the same edge survives
//   rsp_valid - response at buffer head
//   rsp_ready - consumer takes the response
//   rsp_addr  - request address echoed
//   rsp_instr - word i in bits [i*XLEN +: XLEN]
//   rsp_fault - bit0 misaligned, bit1 out of range
module imem_pipelined
  import imem_pipelined_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = XLEN,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned FETCH_WORDS = 1,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic                        flush,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ADDR_WIDTH-1:0]       rsp_addr,
  output logic [FETCH_WORDS*XLEN-1:0] rsp_instr,
  output logic [1:0]                  rsp_fault
);

  localparam int unsigned INDEX_WIDTH = $clog2(MEM_DEPTH);
  localparam int unsigned IDX_EXT_W   = INDEX_WIDTH + 1;
  localparam int unsigned INSTR_WIDTH = FETCH_WORDS * XLEN;
  localparam int unsigned CREDITS     = LATENCY + 2;
  localparam int unsigned CNT_WIDTH   = $clog2(CREDITS + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [INSTR_WIDTH-1:0] instr;
    imem_fault_t            fault;
  } rsp_t;

  // Read-only image; contents survive reset.
  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  rsp_t                 fetch_d;
  rsp_t                 rsp_head;
  logic [LATENCY-1:0]   pipe_valid_d, pipe_valid_q;
  rsp_t                 pipe_data_q [LATENCY];
  logic [CNT_WIDTH-1:0] outstanding_d, outstanding_q;

  assign req_ready = rst_n && (outstanding_q < CNT_WIDTH'(CREDITS));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  // A pop coinciding with a flush is dropped; the buffer is being emptied anyway.
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign push      = pipe_valid_q[LATENCY-1] && !flush;

  // Fault decode and memory read for the stage-1 register.
  always_comb begin
    logic                   misaligned;
    logic                   high_oor;
    logic [ADDR_WIDTH:0]    addr_ext;
    logic [INDEX_WIDTH-1:0] base_idx;
    logic [IDX_EXT_W-1:0]   word_idx;

    addr_ext   = {1'b0, req_addr};
    misaligned = (req_addr[1:0] != 2'b00);
    // Any byte-address bit above the word index means the base is beyond the array.
    high_oor   = ((addr_ext >> (INDEX_WIDTH + 2)) != '0);
    base_idx   = req_addr[INDEX_WIDTH+1:2];
    word_idx   = '0;

    fetch_d                  = '0;
    fetch_d.addr             = req_addr;
    fetch_d.fault.misaligned = misaligned;
    fetch_d.fault.oor        = high_oor;
    for (int unsigned i = 0; i < FETCH_WORDS; i++) begin
      // One extra index bit catches words running off the end instead of wrapping.
      word_idx = {1'b0, base_idx} + IDX_EXT_W'(i);
      if (misaligned || high_oor || word_idx[INDEX_WIDTH]) begin
        fetch_d.instr[i*XLEN +: XLEN] = NOP_INSTR;
      end else begin
        fetch_d.instr[i*XLEN +: XLEN] = mem[word_idx[INDEX_WIDTH-1:0]];
      end
      if (word_idx[INDEX_WIDTH]) fetch_d.fault.oor = 1'b1;
    end
  end

  // Flush kills every in-flight stage but lets the same-edge request enter stage 1.
  always_comb begin
    pipe_valid_d    = '0;
    pipe_valid_d[0] = accept;
    for (int unsigned j = 1; j < LATENCY; j++) begin
      pipe_valid_d[j] = pipe_valid_q[j-1] && !flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= '0;
      for (int unsigned j = 0; j < LATENCY; j++) begin
        pipe_data_q[j] <= '0;
      end
    end else begin
      pipe_valid_q <= pipe_valid_d;
      if (accept) pipe_data_q[0] <= fetch_d;
      for (int unsigned j = 1; j < LATENCY; j++) begin
        pipe_data_q[j] <= pipe_data_q[j-1];
      end
    end
  end

  // Credits cover everything between acceptance and pop.
  always_comb begin
    outstanding_d = outstanding_q;
    if (flush) begin
      outstanding_d = accept ? CNT_WIDTH'(1) : '0;
    end else if (accept && !pop) begin
      outstanding_d = outstanding_q + CNT_WIDTH'(1);
    end else if (!accept && pop) begin
      outstanding_d = outstanding_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  imem_rsp_fifo #(
    .Width($bits(rsp_t)),
    .Depth(CREDITS)
  ) u_rsp_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (flush),
    .push_i     (push),
    .push_data_i(pipe_data_q[LATENCY-1]),
    .pop_i      (pop),
    .head_o     (rsp_head),
    .empty_o    (fifo_empty)
  );

  assign rsp_addr  = rsp_head.addr;
  assign rsp_instr = rsp_head.instr;
  assign rsp_fault = rsp_head.fault;

endmodule

// File: tb/tb_imem_pipelined.sv
// Bench for imem_pipelined: randomized and directed stimulus against a queue-based model.
module tb_imem_pipelined;

  localparam int unsigned LAT     = 3;
  localparam int unsigned FW      = 2;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned AW      = 32;
  localparam int unsigned CREDITS = LAT + 2;
  localparam int unsigned IW      = FW * 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          flush = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] rsp_addr;
  logic [IW-1:0] rsp_instr;
  logic [1:0]    rsp_fault;

  imem_pipelined #(
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .FETCH_WORDS(FW),
    .LATENCY    (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .flush    (flush),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_addr (rsp_addr),
    .rsp_instr(rsp_instr),
    .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   addr;
    logic [IW-1:0] instr;
    logic [1:0]    fault;
    int unsigned   ready_edge;
  } exp_t;

  logic [31:0] shadow [DEPTH];
  exp_t        q[$];
  int unsigned edges = 0;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected response straight from the address rules.
  function automatic void model_rsp(input logic [31:0] a, output logic [IW-1:0] instr,
                                    output logic [1:0] f);
    int unsigned base;
    logic        beyond;
    f      = 2'b00;
    instr  = '0;
    beyond = (a >= 32'(4 * DEPTH));
    if (a[1:0] != 2'b00) f[0] = 1'b1;
    if (beyond) f[1] = 1'b1;
    base = a / 4;
    for (int i = 0; i < FW; i++) begin
      if (!beyond && (base + i >= DEPTH)) f[1] = 1'b1;
      if (f[0] || beyond || (base + i >= DEPTH)) instr[i*32 +: 32] = NOP;
      else instr[i*32 +: 32] = shadow[base + i];
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    int unsigned w = $urandom_range(0, DEPTH - 1);
    if (r <= 6) return 32'(w * 4);
    if (r == 7) return 32'(w * 4 + $urandom_range(1, 3));
    if (r == 8) return $urandom() | 32'h0000_1000;
    return 32'hFF0 + 32'($urandom_range(0, 15));
  endfunction

  // Model: advances on every rising edge using only inputs and its own queue.
  initial begin
    exp_t        e;
    logic        cur_ready;
    logic        cur_valid;
    forever begin
      @(posedge clk);
      cur_ready = rst_n && (q.size() < CREDITS);
      cur_valid = rst_n && (q.size() > 0) && (q[0].ready_edge <= edges);
      edges++;
      if (!rst_n) begin
        q.delete();
      end else begin
        if (flush) q.delete();
        else if (cur_valid && rsp_ready) void'(q.pop_front());
        if (req_valid && cur_ready) begin
          e.addr = req_addr;
          model_rsp(req_addr, e.instr, e.fault);
          e.ready_edge = edges + LAT;
          q.push_back(e);
        end
      end
    end
  end

  // Compare process: checks DUT outputs every falling edge.
  initial begin
    logic exp_v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", {rsp_addr, rsp_instr, rsp_fault}, 0);
      end else begin
        exp_v = (q.size() > 0) && (q[0].ready_edge <= edges);
        chk("rsp_valid", rsp_valid, exp_v);
        chk("req_ready", req_ready, q.size() < CREDITS);
        if (exp_v && rsp_valid) begin
          chk("rsp_addr", rsp_addr, q[0].addr);
          chk("rsp_instr", rsp_instr, q[0].instr);
          chk("rsp_fault", rsp_fault, q[0].fault);
        end
      end
    end
  end

  // Stimulus steps begin 1 time unit after a rising edge.
  task automatic issue(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] a, input logic [IW-1:0] ins,
                           input logic [1:0] f);
    @(negedge clk);
    chk({name, " valid"}, rsp_valid, 1);
    chk({name, " addr"}, rsp_addr, a);
    chk({name, " instr"}, rsp_instr, ins);
    chk({name, " fault"}, rsp_fault, f);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int stalls;

    for (int i = 0; i < DEPTH; i++) shadow[i] = $urandom();
    shadow[0]    = 32'h0050_0093;
    shadow[1]    = 32'h0010_0113;
    shadow[1023] = 32'h00A0_0513;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = shadow[i];

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready after release", req_ready, 1);
    @(posedge clk);
    #1;

    // Back-to-back fetch of the first two words.
    rsp_ready = 1'b1;
    issue(32'h0);
    issue(32'h4);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("first fetch valid", rsp_valid, 1);
    chk("first fetch instr", rsp_instr, {32'h0010_0113, 32'h0050_0093});
    chk("first fetch fault", rsp_fault, 2'b00);
    @(negedge clk);
    chk("second fetch word0", rsp_instr[31:0], 32'h0010_0113);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fault decode.
    issue(32'hFFC);
    issue(32'h6);
    issue(32'h1000);
    issue(32'hFFE);
    repeat (2) @(posedge clk);
    #1;
    pop_check("end of array", 32'hFFC, {NOP, 32'h00A0_0513}, 2'b10);
    pop_check("misaligned", 32'h6, {NOP, NOP}, 2'b01);
    pop_check("beyond array", 32'h1000, {NOP, NOP}, 2'b10);
    pop_check("both faults", 32'hFFE, {NOP, NOP}, 2'b11);

    // Back-pressure: exactly CREDITS accepted.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_addr = 32'(i * 8);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("bp accepted", acc, CREDITS);
    chk("bp req_ready low", req_ready, 0);
    rsp_ready = 1'b1;
    repeat (LAT + CREDITS + 2) @(posedge clk);
    #1;
    chk("bp drained ready", req_ready, 1);
    chk("bp drained valid", rsp_valid, 0);

    // Sustained throughput.
    req_valid = 1'b1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      req_addr = 32'h200 + 32'(i * 4);
      @(negedge clk);
      if (!req_ready) stalls++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("tput stalls", stalls, 0);
    repeat (LAT + 2) @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Flush with a same-edge redirect.
    issue(32'h100);
    issue(32'h104);
    issue(32'h108);
    req_valid = 1'b1;
    req_addr  = 32'h40;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("flush not early", rsp_valid, 0);
    @(negedge clk);
    chk("flush target valid", rsp_valid, 1);
    chk("flush target addr", rsp_addr, 32'h40);
    chk("flush target instr", rsp_instr, {shadow[17], shadow[16]});
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush only one rsp", rsp_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_addr  = rand_addr();
      rsp_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    flush     = 1'b0;

    // Reset with responses buffered.
    rsp_ready = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    issue(32'h300);
    issue(32'h304);
    issue(32'h308);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("pre-reset buffered", rsp_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset drops rsp", rsp_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (LAT + 5) @(posedge clk);
    #1;
    chk("no stale rsp", rsp_valid, 0);
    chk("ready after reset", req_ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
